// File: rtl/instr_fetch_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_seq_if
// Brief    : Control, memory and issue signals of the instruction fetch
//            sequencer, bundled for the sequencer and its environment.
// Revision : 1.0  initial release
// ============================================================================
interface instr_fetch_seq_if;
    logic        run;
    logic        stall;
    logic        branch;
    logic [11:0] branch_addr;
    logic        mem_rd;
    logic [11:0] mem_addr;
    logic        mem_ready;
    logic [15:0] mem_data;
    logic [14:0] instr;
    logic        tp;
    logic [11:0] pc;
    logic        parity_err;

    // The sequencer masters the memory read and drives the decode side.
    modport master (
        input  run, stall, branch, branch_addr, mem_ready, mem_data,
        output mem_rd, mem_addr, instr, tp, pc, parity_err
    );

    modport slave (
        output run, stall, branch, branch_addr, mem_ready, mem_data,
        input  mem_rd, mem_addr, instr, tp, pc, parity_err
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_seq.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_seq
// Brief    : Single-outstanding instruction fetch sequencer with branch
//            redirect, downstream stall hold and sticky odd-parity halt.
// Revision : 1.0  initial release
// ============================================================================
module instr_fetch_seq (
    input  logic              clk,
    input  logic              reset,
    instr_fetch_seq_if.master bus
);

    localparam logic [11:0] C_PC_RESET = 12'h800;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_HOLD  = 3'd2,
        S_ISSUE = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t      r_state;
    logic [11:0] r_pc;
    logic [15:0] r_data;
    logic        r_mem_rd;
    logic        r_tp;
    logic [14:0] r_instr;
    logic        r_parity_err;

    state_t      w_state_nxt;
    logic [11:0] w_pc_nxt;
    logic [15:0] w_data_nxt;
    logic        w_mem_rd_nxt;
    logic        w_tp_nxt;
    logic [14:0] w_instr_nxt;
    logic        w_parity_err_nxt;
    logic        w_parity_ok;

    // A valid word carries an odd number of ones across all 16 bits.
    assign w_parity_ok = ^r_data;

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_data_nxt       = r_data;
        w_parity_err_nxt = r_parity_err;

        case (r_state)
            S_IDLE: begin
                if (bus.branch) begin
                    w_pc_nxt = bus.branch_addr;
                end
                if (bus.run) begin
                    w_state_nxt = S_FETCH;
                end
            end

            S_FETCH: begin
                // A redirect wins over returning data; the stale word is dropped.
                if (bus.branch) begin
                    w_pc_nxt = bus.branch_addr;
                end else if (bus.mem_ready) begin
                    w_data_nxt  = bus.mem_data;
                    w_state_nxt = bus.stall ? S_HOLD : S_ISSUE;
                end
            end

            S_HOLD: begin
                if (bus.branch) begin
                    w_pc_nxt    = bus.branch_addr;
                    w_data_nxt  = '0;
                    w_state_nxt = S_FETCH;
                end else if (!bus.stall) begin
                    w_state_nxt = S_ISSUE;
                end
            end

            S_ISSUE: begin
                w_pc_nxt = bus.branch ? bus.branch_addr : r_pc + 12'd1;
                if (!w_parity_ok) begin
                    w_parity_err_nxt = 1'b1;
                    w_state_nxt      = S_HALT;
                end else begin
                    w_state_nxt = bus.run ? S_FETCH : S_IDLE;
                end
            end

            S_HALT: begin
                w_state_nxt = S_HALT;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they leave a flop.
        w_mem_rd_nxt = (w_state_nxt == S_FETCH);
        w_tp_nxt     = (w_state_nxt == S_ISSUE);
        w_instr_nxt  = w_tp_nxt ? w_data_nxt[14:0] : r_instr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_pc         <= C_PC_RESET;
            r_data       <= '0;
            r_mem_rd     <= 1'b0;
            r_tp         <= 1'b0;
            r_instr      <= '0;
            r_parity_err <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_data       <= w_data_nxt;
            r_mem_rd     <= w_mem_rd_nxt;
            r_tp         <= w_tp_nxt;
            r_instr      <= w_instr_nxt;
            r_parity_err <= w_parity_err_nxt;
        end
    end

    // The read address is the program counter flop itself, so it always tracks pc.
    assign bus.mem_rd     = r_mem_rd;
    assign bus.mem_addr   = r_pc;
    assign bus.tp         = r_tp;
    assign bus.instr      = r_instr;
    assign bus.pc         = r_pc;
    assign bus.parity_err = r_parity_err;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_seq
// Brief    : Self-checking bench for instr_fetch_seq (vector table plus
//            directed sequences, issued words checked through a queue).
// Revision : 1.0  initial release
// ============================================================================
module tb_instr_fetch_seq;

    logic clk;
    logic reset;

    instr_fetch_seq_if bus ();

    instr_fetch_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [14:0] exp_q[$];

    typedef struct {
        logic [11:0] start;
        int          lat;
        int          hold;
        logic [15:0] data;
        logic [14:0] exp_instr;
        logic [11:0] exp_pc;
        logic        exp_perr;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] make_word(input logic [11:0] a);
        logic [15:0] w;
        w     = {4'b0000, a};
        w[15] = ~(^w[14:0]);
        return w;
    endfunction

    // Every tp pulse must match the oldest outstanding expected word.
    always @(negedge clk) begin
        if (bus.tp === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_tp: got instr %0h expected no issue at %0t",
                         bus.instr, $time);
            end else begin
                chk("issued_instr", bus.instr, exp_q.pop_front());
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    task automatic do_reset();
        bus.run       = 1'b0;
        bus.stall     = 1'b0;
        bus.branch    = 1'b0;
        bus.mem_ready = 1'b0;
        reset         = 1'b1;
        tick();
        chk("rst_mem_rd", bus.mem_rd, 0);
        chk("rst_tp", bus.tp, 0);
        chk("rst_instr", bus.instr, 0);
        chk("rst_pc", bus.pc, 12'h800);
        chk("rst_mem_addr", bus.mem_addr, 12'h800);
        chk("rst_parity_err", bus.parity_err, 0);
        reset = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        bus.run         = 1'b0;
        bus.stall       = 1'b0;
        bus.branch      = 1'b0;
        bus.branch_addr = 12'h000;
        bus.mem_ready   = 1'b0;
        bus.mem_data    = 16'h0000;

        //              start    lat hold data      instr     pc       perr
        vecs[0] = '{12'h800, 0, 0, 16'h8001, 15'h0001, 12'h801, 1'b1};
        vecs[1] = '{12'h800, 3, 2, 16'h1234, 15'h1234, 12'h801, 1'b0};
        vecs[2] = '{12'hFFF, 0, 0, 16'h0007, 15'h0007, 12'h000, 1'b0};
        vecs[3] = '{12'h123, 1, 1, 16'hFFFE, 15'h7FFE, 12'h124, 1'b0};
        vecs[4] = '{12'h800, 0, 0, 16'h0003, 15'h0003, 12'h801, 1'b1};
        vecs[5] = '{12'h5A5, 0, 3, 16'h4000, 15'h4000, 12'h5A6, 1'b0};
        vecs[6] = '{12'h800, 2, 0, 16'h8000, 15'h0000, 12'h801, 1'b0};

        for (int v = 0; v < 7; v++) begin
            do_reset();
            if (vecs[v].start != 12'h800) begin
                bus.branch      = 1'b1;
                bus.branch_addr = vecs[v].start;
                tick();
                bus.branch = 1'b0;
                chk("idle_branch_pc", bus.pc, vecs[v].start);
                chk("idle_branch_mem_rd", bus.mem_rd, 0);
            end
            bus.run = 1'b1;
            tick();
            bus.run = 1'b0;
            for (int i = 0; i < vecs[v].lat; i++) begin
                chk("wait_mem_rd", bus.mem_rd, 1);
                chk("wait_mem_addr", bus.mem_addr, vecs[v].start);
                tick();
            end
            chk("fetch_mem_rd", bus.mem_rd, 1);
            chk("fetch_mem_addr", bus.mem_addr, vecs[v].start);
            bus.mem_ready = 1'b1;
            bus.mem_data  = vecs[v].data;
            bus.stall     = (vecs[v].hold > 0);
            exp_q.push_back(vecs[v].exp_instr);
            tick();
            bus.mem_ready = 1'b0;
            bus.mem_data  = 16'hDEAD;
            for (int i = 0; i < vecs[v].hold; i++) begin
                chk("hold_mem_rd", bus.mem_rd, 0);
                chk("hold_tp", bus.tp, 0);
                if (i == vecs[v].hold - 1) bus.stall = 1'b0;
                tick();
            end
            chk("issue_tp", bus.tp, 1);
            tick();
            chk("post_tp", bus.tp, 0);
            chk("post_pc", bus.pc, vecs[v].exp_pc);
            chk("post_parity_err", bus.parity_err, vecs[v].exp_perr);
            chk("post_mem_rd", bus.mem_rd, 0);
            if (vecs[v].exp_perr) begin
                bus.run         = 1'b1;
                bus.branch      = 1'b1;
                bus.branch_addr = 12'h555;
                bus.mem_ready   = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    tick();
                    chk("halt_mem_rd", bus.mem_rd, 0);
                    chk("halt_tp", bus.tp, 0);
                end
                bus.run       = 1'b0;
                bus.branch    = 1'b0;
                bus.mem_ready = 1'b0;
                chk("halt_pc", bus.pc, vecs[v].exp_pc);
                chk("halt_parity_err", bus.parity_err, 1);
            end
        end

        // Branch arriving with mem_ready in FETCH: data dropped, refetch at target.
        do_reset();
        bus.run = 1'b1;
        tick();
        bus.run = 1'b0;
        chk("br_fetch_mem_rd", bus.mem_rd, 1);
        bus.mem_ready   = 1'b1;
        bus.mem_data    = 16'h8001;
        bus.branch      = 1'b1;
        bus.branch_addr = 12'h123;
        tick();
        bus.branch = 1'b0;
        chk("br_fetch_tp", bus.tp, 0);
        chk("br_fetch_mem_rd2", bus.mem_rd, 1);
        chk("br_fetch_mem_addr", bus.mem_addr, 12'h123);
        bus.mem_data = 16'h8123;
        exp_q.push_back(15'h0123);
        tick();
        bus.mem_ready = 1'b0;
        chk("br_issue_tp", bus.tp, 1);
        tick();
        chk("br_post_pc", bus.pc, 12'h124);

        // Steady state with zero-wait memory: first issue at cycle 2, then every 2.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            logic [11:0] a;
            a = 12'h800 + 12'(k);
            exp_q.push_back({3'b000, a});
        end
        begin
            int n_tp;
            n_tp    = 0;
            bus.run = 1'b1;
            for (int c = 0; c < 20; c++) begin
                bus.mem_ready = 1'b1;
                bus.mem_data  = make_word(bus.mem_addr);
                tick();
                if (c == 0) begin
                    chk("lat_mem_rd_c1", bus.mem_rd, 1);
                    chk("lat_tp_c1", bus.tp, 0);
                end
                if (c == 1) chk("lat_tp_c2", bus.tp, 1);
                if (bus.tp === 1'b1) n_tp++;
            end
            chk("steady_issue_count", n_tp, 10);
        end
        bus.run       = 1'b0;
        bus.mem_ready = 1'b0;
        tick();
        tick();
        chk("steady_queue_drained", exp_q.size(), 0);

        // Reset mid-FETCH while data returns: nothing issues, outputs reset.
        bus.run = 1'b1;
        tick();
        bus.run = 1'b0;
        chk("rf_mem_rd", bus.mem_rd, 1);
        reset         = 1'b1;
        bus.mem_ready = 1'b1;
        bus.mem_data  = 16'h8001;
        tick();
        reset = 1'b0;
        chk("rf_mem_rd_rst", bus.mem_rd, 0);
        chk("rf_tp_rst", bus.tp, 0);
        chk("rf_instr_rst", bus.instr, 0);
        chk("rf_pc_rst", bus.pc, 12'h800);
        chk("rf_mem_addr_rst", bus.mem_addr, 12'h800);
        chk("rf_parity_err_rst", bus.parity_err, 0);
        tick();
        bus.mem_ready = 1'b0;
        chk("rf_late_data_tp", bus.tp, 0);
        chk("rf_late_data_mem_rd", bus.mem_rd, 0);
        tick();
        chk("rf_idle_tp", bus.tp, 0);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_fetch_seq.md
INSTR_FETCH_SEQ -- requirements
Module: instr_fetch_seq

Interface
REQ-001 clk  in  1  system clock; all state changes on its rising edge.
REQ-002 reset  in  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 run  in  1  fetch enable; sampled only in IDLE and ISSUE.
REQ-004 stall  in  1  downstream not ready; delays instruction issue.
REQ-005 branch  in  1  one-cycle request to load the program counter.
REQ-006 branch_addr  in  12  new program counter value, valid when branch=1.
REQ-007 mem_rd  out  1  memory read request, held until mem_ready is accepted.
REQ-008 mem_addr  out  12  read address, equal to pc whenever mem_rd=1.
REQ-009 mem_ready  in  1  memory data valid this cycle.
REQ-010 mem_data  in  16  bits [14:0] instruction word; bit [15] parity.
REQ-011 instr  out  15  issued instruction word, valid when tp=1 and held until the next issue.
REQ-012 tp  out  1  one-cycle instruction-valid strobe to the decode stage.
REQ-013 pc  out  12  current program counter (Z).
REQ-014 parity_err  out  1  sticky parity failure flag.

Function
REQ-015 The block SHALL implement the states IDLE, FETCH, HOLD, ISSUE and HALT, encoded in a single registered state variable.
REQ-016 All outputs SHALL be registered, with no combinational path from input to output.
REQ-017 IDLE: when run=1, the block SHALL move to FETCH with mem_rd=1 and mem_addr=pc on the next cycle; otherwise it SHALL stay in IDLE.
REQ-018 FETCH, mem_rd=1: if mem_ready=1 and stall=0, the block SHALL capture mem_data and move to ISSUE; if mem_ready=1 and stall=1, it SHALL capture mem_data and move to HOLD; otherwise it SHALL stay in FETCH.
REQ-019 HOLD, mem_rd=0: the block SHALL move to ISSUE on the first cycle with stall=0; captured data SHALL be retained.
REQ-020 ISSUE: tp=1 for exactly one cycle and instr=captured[14:0].
REQ-021 On leaving ISSUE, pc SHALL load branch_addr if branch=1, else pc+1 modulo 4096 (12'hFFF wraps to 12'h000).
REQ-022 On leaving ISSUE without a parity error, the block SHALL go to FETCH if run=1, else to IDLE.
REQ-023 Parity: the 16-bit captured word SHALL have an odd number of ones. An even count detected in ISSUE SHALL set parity_err=1 and move the block to HALT; tp SHALL still pulse for that word.
REQ-024 HALT SHALL keep mem_rd=0 and tp=0, and SHALL be left only by reset.
REQ-025 Branch in FETCH: pc<=branch_addr; state stays FETCH; mem_addr SHALL update the next cycle; any mem_ready in the same cycle SHALL be discarded, with no transition.
REQ-026 Branch in HOLD: pc<=branch_addr; captured data SHALL be discarded; the block SHALL move to FETCH.
REQ-027 Branch in IDLE: pc<=branch_addr; the state SHALL not change unless run=1.
REQ-028 Branch in HALT SHALL be ignored.
REQ-029 Deasserting run during FETCH or HOLD SHALL NOT abort the fetch; the word SHALL still issue.
REQ-030 Latency: with mem_ready tied high and stall=0, run sampled high in cycle 0 SHALL give mem_rd=1 in cycle 1 and tp=1 in cycle 2; steady-state issue SHALL be one instruction per 2 cycles.

Reset
REQ-031 reset=1 SHALL force the state to IDLE, pc=12'h800 (octal 4000), mem_addr=12'h800, mem_rd=0, tp=0, instr=0 and parity_err=0 on the next edge.
REQ-032 Reset SHALL have priority over every other input, including mid-FETCH; memory data returning after reset SHALL be ignored.

Verification
REQ-033 Reset, then run=1, zero-wait memory returning 16'h8001 at 12'h800 -> mem_rd at cycle 1 with mem_addr=12'h800; tp at cycle 2 with instr=15'h0001; pc=12'h801.
REQ-034 mem_ready delayed 3 cycles, stall=1 for 2 cycles after data -> mem_rd high 4 cycles, then HOLD 2 cycles, then a single tp pulse; no duplicate or lost word.
REQ-035 pc preloaded to 12'hFFF by branch, fetch one word -> after tp, pc=12'h000.
REQ-036 branch with branch_addr=12'h123 in the same cycle as mem_ready in FETCH -> no tp; next mem_addr=12'h123; the subsequent issue uses the 12'h123 data.
REQ-037 mem_data=16'h0003 (even parity) -> tp pulses once, parity_err=1, then no further mem_rd; reset clears parity_err and resumes at 12'h800.
REQ-038 Reset asserted mid-FETCH while mem_ready arrives in the same cycle -> no tp; all outputs at their reset values next cycle.
